// File: rtl/dbg_uart_framer.sv
// dbg_uart_framer: snapshots core debug state on each cpu_clk rising edge and streams it to the UART byte by byte.
// Optional DBG_FRAMER_SYNC_EN adds a leading sync byte and a trailing XOR checksum (16-byte frame instead of 14).
module dbg_uart_framer #(
  parameter int ACK_TIMEOUT = 16
`ifdef DBG_FRAMER_SYNC_EN
  , parameter logic [7:0] SYNC_BYTE = 8'hA5
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cpu_clk,
  input  logic [15:0] dbg_pc,
  input  logic [15:0] dbg_sp,
  input  logic [15:0] dbg_AF,
  input  logic [15:0] dbg_BC,
  input  logic [15:0] dbg_DE,
  input  logic [15:0] dbg_HL,
  input  logic [7:0]  dbg_last_opcode,
  input  logic [5:0]  dbg_stage,
  input  logic        dbg_instruction_retired,
  input  logic        dbg_halted,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  output logic        busy,
  output logic [7:0]  dropped
);

`ifdef DBG_FRAMER_SYNC_EN
  localparam int NBYTES = 16;
`else
  localparam int NBYTES = 14;
`endif
  localparam logic [3:0] LAST = 4'(NBYTES - 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_FREE, WAIT_ACK, WAIT_DONE, NEXT} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, hist, trig, capture, ack_timeout;
  logic [3:0]      idx;
  logic [TW-1:0]   to_cnt;
  logic [7:0]      tx_hold;
  logic [7:0]      payload [14];
  logic [7:0]      snap    [NBYTES];
  logic [7:0]      frame   [NBYTES];

  always_comb begin
    payload[0]  = {dbg_halted, dbg_instruction_retired, dbg_stage};
    payload[1]  = dbg_pc[15:8];
    payload[2]  = dbg_pc[7:0];
    payload[3]  = dbg_sp[15:8];
    payload[4]  = dbg_sp[7:0];
    payload[5]  = dbg_AF[15:8];
    payload[6]  = dbg_AF[7:0];
    payload[7]  = dbg_BC[15:8];
    payload[8]  = dbg_BC[7:0];
    payload[9]  = dbg_DE[15:8];
    payload[10] = dbg_DE[7:0];
    payload[11] = dbg_HL[15:8];
    payload[12] = dbg_HL[7:0];
    payload[13] = dbg_last_opcode;
  end

`ifdef DBG_FRAMER_SYNC_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < 14; i++) csum = csum ^ payload[i];
    snap[0] = SYNC_BYTE;
    for (int i = 0; i < 14; i++) snap[i+1] = payload[i];
    snap[15] = csum;
  end
`else
  always_comb begin
    for (int i = 0; i < 14; i++) snap[i] = payload[i];
  end
`endif

  // cpu_clk is phase-asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= cpu_clk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign trig        = sync2 & ~hist;
  assign capture     = (state == IDLE) && trig && enable;
  assign ack_timeout = (to_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (capture) state_nxt = WAIT_FREE;
      WAIT_FREE: if (!is_transmitting) state_nxt = WAIT_ACK;
      WAIT_ACK:  if (is_transmitting) state_nxt = WAIT_DONE;
                 else if (ack_timeout) state_nxt = NEXT;
      WAIT_DONE: if (!is_transmitting) state_nxt = NEXT;
      NEXT:      state_nxt = (idx == LAST) ? IDLE : WAIT_FREE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Strobe is combinational so the first byte leaves one cycle after trig on an idle UART
  always_comb begin
    transmit = 1'b0;
    busy     = (state != IDLE);
    tx_byte  = tx_hold;
    if (state == WAIT_FREE && !is_transmitting) begin
      transmit = 1'b1;
      tx_byte  = frame[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      to_cnt  <= '0;
      tx_hold <= '0;
      dropped <= '0;
      for (int i = 0; i < NBYTES; i++) frame[i] <= '0;
    end else begin
      if (capture) begin
        idx <= '0;
        for (int i = 0; i < NBYTES; i++) frame[i] <= snap[i];
      end else if (state == NEXT && idx != LAST) begin
        idx <= idx + 4'd1;
      end
      if (state == WAIT_ACK) to_cnt <= to_cnt + 1'b1;
      else                   to_cnt <= '0;
      if (transmit) tx_hold <= frame[idx];
      if (trig && state != IDLE && dropped != 8'hFF) dropped <= dropped + 8'd1;
    end
  end

endmodule
